// File: rtl/operand_deserializer_pkg.sv
// Shared constants and state encoding for the serial operand bank loader.
package operand_deserializer_pkg;
  localparam int ROW_W = 70;  // {uncertainty[5:0], operand[63:0]}
  localparam int ROWS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Row order within a frame: a,b,c triplets for lanes 0..3
  localparam int ROW_A0 = 0, ROW_B0 = 1,  ROW_C0 = 2;
  localparam int ROW_A1 = 3, ROW_B1 = 4,  ROW_C1 = 5;
  localparam int ROW_A2 = 6, ROW_B2 = 7,  ROW_C2 = 8;
  localparam int ROW_A3 = 9, ROW_B3 = 10, ROW_C3 = 11;
endpackage

// File: rtl/operand_deserializer_row_shifter.sv
// One-row serial-to-parallel shifter; row_done flags the edge that takes the last bit.
module row_shifter #(
  parameter int ROW_W = 70
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [ROW_W-1:0] row_next,
  output logic             row_done
);
  localparam int CNT_W = $clog2(ROW_W + 1);

  // Only ROW_W-1 bits are stored; the final bit arrives live on din.
  logic [ROW_W-2:0] sr;
  logic [CNT_W-1:0] bit_cnt;

  assign row_next = {sr, din};
  assign row_done = shift && (bit_cnt == CNT_W'(ROW_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= row_next[ROW_W-2:0];
      bit_cnt <= row_done ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/operand_deserializer.sv
// Serial operand loader: shifts ROWS rows of ROW_W bits into a parallel bank for the fma.
module operand_deserializer #(
  parameter int ROW_W = operand_deserializer_pkg::ROW_W,
  parameter int ROWS  = operand_deserializer_pkg::ROWS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  din,
  input  logic                  abort,
  input  logic                  ack,
  output logic [ROWS*ROW_W-1:0] bank,
  output logic [3:0]            row_idx,
  output logic                  row_valid,
  output logic                  load,
  output logic                  busy,
  output logic                  ovf
);
  import operand_deserializer_pkg::*;

  state_t                     state;
  logic [3:0]                 row_cnt;
  logic [ROWS-1:0][ROW_W-1:0] bank_r;
  logic [ROW_W-1:0]           row_next;
  logic                       row_done;
  logic                       shift;

  // A held frame only accepts a new bit when the consumer acks in the same cycle.
  assign shift = en && !abort && ((state != FULL) || ack);
  assign bank  = bank_r;

  row_shifter #(.ROW_W(ROW_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .shift    (shift),
    .din      (din),
    .row_next (row_next),
    .row_done (row_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      bank_r    <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      load      <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        row_cnt <= '0;
        load    <= 1'b0;
        busy    <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (en) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            row_cnt <= '0;
          end
          SHIFT: if (row_done) begin
            bank_r[row_cnt] <= row_next;
            row_valid       <= 1'b1;
            row_idx         <= row_cnt;
            if (row_cnt == 4'(ROWS - 1)) begin
              state   <= FULL;
              load    <= 1'b1;
              busy    <= 1'b0;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
          FULL: begin
            if (ack) begin
              load    <= 1'b0;
              row_cnt <= '0;
              state   <= en ? SHIFT : IDLE;
              busy    <= en;
            end else if (en) begin
              ovf <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_operand_deserializer.sv
// Randomized bench for operand_deserializer against a bit-stream frame model.
module tb_operand_deserializer;
  localparam int ROW_W = 70;
  localparam int ROWS  = 12;

  logic clk = 1'b0;
  logic rst, en, din, abort, ack;
  logic [ROWS*ROW_W-1:0] bank;
  logic [3:0] row_idx;
  logic row_valid, load, busy, ovf;

  operand_deserializer #(.ROW_W(ROW_W), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .abort(abort), .ack(ack),
    .bank(bank), .row_idx(row_idx), .row_valid(row_valid), .load(load),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a frame is a stream of bits; every ROW_W bits make one row, ROWS rows make a frame.
  logic [ROW_W-1:0] exp_bank [ROWS];
  logic [ROW_W-1:0] m_acc;
  int   m_nbits, m_row;
  logic m_held, m_busy, m_ovf, m_rv;
  logic [3:0] m_idx;

  function automatic logic [ROWS*ROW_W-1:0] exp_flat();
    logic [ROWS*ROW_W-1:0] f;
    for (int r = 0; r < ROWS; r++) f[r*ROW_W +: ROW_W] = exp_bank[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) exp_bank[r] = '0;
    m_acc = '0; m_nbits = 0; m_row = 0;
    m_held = 0; m_busy = 0; m_ovf = 0; m_rv = 0; m_idx = '0;
  endtask

  task automatic tick(input logic e, input logic d, input logic ab, input logic ak);
    en = e; din = d; abort = ab; ack = ak;
    @(posedge clk); #1;
    en = 0; din = 0; abort = 0; ack = 0;
    m_rv = 0;
    if (ab) begin
      m_acc = '0; m_nbits = 0; m_row = 0; m_held = 0; m_busy = 0; m_ovf = 0;
    end else if (m_held) begin
      if (ak) begin
        m_held = 0; m_row = 0; m_nbits = 0; m_busy = e;
        if (e) begin m_acc = {m_acc[ROW_W-2:0], d}; m_nbits = 1; end
      end else if (e) begin
        m_ovf = 1;
      end
    end else if (e) begin
      m_acc = {m_acc[ROW_W-2:0], d};
      m_nbits++;
      m_busy = 1;
      if (m_nbits == ROW_W) begin
        exp_bank[m_row] = m_acc;
        m_rv = 1; m_idx = 4'(m_row);
        m_nbits = 0; m_row++;
        if (m_row == ROWS) begin m_held = 1; m_busy = 0; m_row = 0; end
      end
    end
  endtask

  // Random rows with random en gaps and stray acks (ignored outside FULL); stops on the n-th row.
  task automatic test_random_rows(input int n);
    int done, guard;
    logic e;
    done = 0; guard = 0;
    while (done < n && guard < n*ROW_W*4) begin
      e = ($urandom_range(0, 3) != 0);
      tick(e, 1'($urandom), 1'b0, 1'($urandom_range(0, 7) == 0));
      if (m_rv) done++;
      guard++;
      checks++;
      if ({row_valid, load, busy, ovf, row_idx} !== {m_rv, m_held, m_busy, m_ovf, m_idx}) begin
        failures++;
        $display("FAIL random_rows status t=%0t got=%b exp=%b", $time,
                 {row_valid, load, busy, ovf, row_idx}, {m_rv, m_held, m_busy, m_ovf, m_idx});
      end
    end
    checks++;
    if (done != n) begin
      failures++;
      $display("FAIL random_rows_timeout rows=%0d want=%0d", done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; din = 0; abort = 0; ack = 0;
    #2;
    checks += 6;
    if (bank !== '0)      begin failures++; $display("FAIL reset_bank got=%h exp=0", bank); end
    if (row_idx !== 4'd0) begin failures++; $display("FAIL reset_row_idx got=%0d exp=0", row_idx); end
    if (row_valid !== 0)  begin failures++; $display("FAIL reset_row_valid got=%b exp=0", row_valid); end
    if (load !== 0)       begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
    if (busy !== 0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ovf !== 0)        begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_frame();
    logic [ROW_W-1:0] v;
    for (int r = 0; r < ROWS; r++) begin
      v = {6'(r), 64'hA5A5_0000_0000_0000 + 64'(r)};
      for (int b = ROW_W-1; b >= 0; b--) begin
        tick(1'b1, v[b], 1'b0, 1'b0);
        checks++;
        if ({row_valid, load, busy, ovf, row_idx} !== {m_rv, m_held, m_busy, m_ovf, m_idx}) begin
          failures++;
          $display("FAIL frame_status r=%0d b=%0d got=%b exp=%b", r, b,
                   {row_valid, load, busy, ovf, row_idx}, {m_rv, m_held, m_busy, m_ovf, m_idx});
        end
        checks++;
        if (b == 0 && (row_valid !== 1'b1 || row_idx !== 4'(r) || load !== (r == ROWS-1))) begin
          failures++;
          $display("FAIL frame_row_done r=%0d got rv=%b idx=%0d load=%b", r, row_valid, row_idx, load);
        end else if (b != 0 && (row_valid !== 1'b0 || load !== 1'b0)) begin
          failures++;
          $display("FAIL frame_mid_row r=%0d b=%0d got rv=%b load=%b exp 0 0", r, b, row_valid, load);
        end
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      v = {6'(r), 64'hA5A5_0000_0000_0000 + 64'(r)};
      checks++;
      if (bank[r*ROW_W +: ROW_W] !== v) begin
        failures++;
        $display("FAIL frame_bank_row r=%0d got=%h exp=%h", r, bank[r*ROW_W +: ROW_W], v);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b1 || bank !== exp_flat()) begin
      failures++;
      $display("FAIL frame_hold got load=%b exp=1", load);
    end
  endtask

  task automatic test_en_gaps();
    logic [ROW_W-1:0] v;
    int pulses;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (load !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gaps_release got load=%b busy=%b exp 0 0", load, busy);
    end
    v = {6'($urandom), $urandom, $urandom};
    pulses = 0;
    for (int i = 0; i < 90; i++) begin
      if (i < 35)      tick(1'b1, v[ROW_W-1-i], 1'b0, 1'b0);
      else if (i < 55) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
      else             tick(1'b1, v[ROW_W-1-(i-20)], 1'b0, 1'b0);
      if (row_valid === 1'b1) pulses++;
      checks++;
      if ({row_valid, load, busy, ovf, row_idx} !== {m_rv, m_held, m_busy, m_ovf, m_idx}) begin
        failures++;
        $display("FAIL gaps_status i=%0d got=%b exp=%b", i,
                 {row_valid, load, busy, ovf, row_idx}, {m_rv, m_held, m_busy, m_ovf, m_idx});
      end
    end
    checks += 2;
    if (pulses != 1) begin failures++; $display("FAIL gaps_pulses got=%0d exp=1", pulses); end
    if (bank[ROW_W-1:0] !== v) begin
      failures++; $display("FAIL gaps_row0 got=%h exp=%h", bank[ROW_W-1:0], v);
    end
    test_random_rows(ROWS - 1);
  endtask

  task automatic test_overflow();
    logic [ROWS*ROW_W-1:0] snap;
    snap = bank;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (ovf !== 1'b1 || load !== 1'b1 || busy !== 1'b0 || bank !== snap) begin
        failures++;
        $display("FAIL ovf_hold i=%0d got ovf=%b load=%b busy=%b bank_same=%b exp 1 1 0 1",
                 i, ovf, load, busy, bank === snap);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (load !== 1'b0 || ovf !== 1'b1 || busy !== 1'b0 || bank !== exp_flat()) begin
      failures++;
      $display("FAIL ovf_ack got load=%b ovf=%b busy=%b exp 0 1 0", load, ovf, busy);
    end
    test_random_rows(ROWS);
  endtask

  task automatic test_ack_en();
    logic [ROW_W-2:0] rest;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (load !== 1'b0 || busy !== 1'b1 || row_valid !== 1'b0) begin
      failures++;
      $display("FAIL acken_handoff got load=%b busy=%b rv=%b exp 0 1 0", load, busy, row_valid);
    end
    rest = {5'($urandom), $urandom, $urandom};
    for (int b = ROW_W-2; b >= 0; b--) tick(1'b1, rest[b], 1'b0, 1'b0);
    checks++;
    if (row_valid !== 1'b1 || row_idx !== 4'd0 || bank[ROW_W-1:0] !== {1'b1, rest}) begin
      failures++;
      $display("FAIL acken_row0 got rv=%b idx=%0d row0=%h exp 1 0 %h",
               row_valid, row_idx, bank[ROW_W-1:0], {1'b1, rest});
    end
  endtask

  task automatic test_abort();
    logic [ROWS*ROW_W-1:0] snap;
    logic [ROW_W-1:0] v;
    test_random_rows(4);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b0);
    snap = bank;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b0 || load !== 1'b0 || ovf !== 1'b0 || row_valid !== 1'b0 || bank !== snap) begin
      failures++;
      $display("FAIL abort_clear got busy=%b load=%b ovf=%b rv=%b bank_same=%b exp 0 0 0 0 1",
               busy, load, ovf, row_valid, bank === snap);
    end
    v = {6'($urandom), $urandom, $urandom};
    for (int b = ROW_W-1; b >= 0; b--) begin
      tick(1'b1, v[b], 1'b0, 1'b0);
      checks++;
      if (row_valid !== (b == 0)) begin
        failures++;
        $display("FAIL abort_restart_rv b=%0d got=%b exp=%b", b, row_valid, b == 0);
      end
    end
    checks++;
    if (row_idx !== 4'd0 || bank !== {snap[ROWS*ROW_W-1:ROW_W], v} || bank !== exp_flat()) begin
      failures++;
      $display("FAIL abort_restart_bank got idx=%0d row0=%h exp 0 %h", row_idx, bank[ROW_W-1:0], v);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 100; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b0);
    #3 rst = 1;
    #1;
    checks++;
    if (bank !== '0 || row_idx !== 4'd0 || row_valid !== 1'b0 || load !== 1'b0 ||
        busy !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got idx=%0d rv=%b load=%b busy=%b ovf=%b bank_zero=%b",
               row_idx, row_valid, load, busy, ovf, bank === '0);
    end
    #1 rst = 0;
    model_reset();
    test_random_rows(ROWS);
    checks++;
    if (load !== 1'b1 || bank !== exp_flat()) begin
      failures++;
      $display("FAIL async_reset_frame got load=%b bank_match=%b exp 1 1", load, bank === exp_flat());
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      tick(1'b1, 1'($urandom), 1'b0, 1'b1);
      checks++;
      if (load !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_handoff f=%0d got load=%b busy=%b exp 0 1", f, load, busy);
      end
      test_random_rows(ROWS);
      checks++;
      if (bank !== exp_flat()) begin
        failures++;
        $display("FAIL b2b_bank f=%0d got=%h exp=%h", f, bank, exp_flat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_en_gaps();
    test_overflow();
    test_ack_en();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/operand_deserializer.md
OPERAND_DESERIALIZER -- requirements
Module: operand_deserializer

Interface
REQ-001 Parameter ROW_W, default 70, bits per row: {uncertainty[5:0], operand[63:0]}.
REQ-002 Parameter ROWS, default 12, rows per frame in order a0,b0,c0,a1,b1,c1,a2,b2,c2,a3,b3,c3.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  serial bit valid; din sampled only when en=1.
REQ-006 din  input  1  serial data bit, MSB of each row first.
REQ-007 abort  input  1  synchronous frame discard.
REQ-008 ack  input  1  consumer has taken the frame.
REQ-009 bank  output  ROWS*ROW_W  operand bank; row r at bits [ROW_W*r+ROW_W-1 : ROW_W*r].
REQ-010 row_idx  output  4  index of the last completed row.
REQ-011 row_valid  output  1  one-cycle pulse per completed row.
REQ-012 load  output  1  frame complete; bank stable; held until ack.
REQ-013 busy  output  1  frame in progress: state SHIFT and at least one bit taken.
REQ-014 ovf  output  1  sticky: bit offered while frame held.

Function
REQ-015 The state machine SHALL have states IDLE, SHIFT, FULL; reset state IDLE.
REQ-016 IDLE: en=1 SHALL shift din into bit 0 of the shift register, set bit_cnt=1, row_cnt=0, and go to SHIFT.
REQ-017 SHIFT: each en=1 cycle SHALL shift left, inserting din at the LSB; en=0 SHALL hold all state, with no timeout.
REQ-018 On the cycle the ROW_W-th bit of a row is shifted, the full row SHALL be written to bank row row_cnt on the same edge.
REQ-019 On that same edge, row_valid SHALL pulse 1 cycle, row_idx SHALL equal row_cnt, bit_cnt SHALL wrap to 0, and row_cnt SHALL increment.
REQ-020 Completing row ROWS-1 SHALL move the block to FULL and assert load on the same edge.
REQ-021 FULL: bank and load SHALL hold; en=1 with ack=0 SHALL discard din and set ovf.
REQ-022 FULL with ack=1 and en=0 SHALL deassert load next cycle, clear counters, and go to IDLE.
REQ-023 FULL with ack=1 and en=1 in the same cycle SHALL deassert load and take din as bit 0 of a new frame, going to SHIFT with bit_cnt=1.
REQ-024 ack outside FULL SHALL be ignored.
REQ-025 abort=1 in any state SHALL clear counters, load, and busy next cycle and go to IDLE; bank SHALL be kept; abort SHALL win over en and ack.
REQ-026 ovf SHALL clear only on reset or abort.
REQ-027 Latency from the last frame bit to load=1 SHALL be 1 clock edge.
REQ-028 Rows not rewritten in a new frame SHALL keep their old contents until overwritten.

Reset
REQ-029 On rst=1, state SHALL be IDLE and every output and register SHALL be zero (bank, row_idx, row_valid, load, busy, ovf, counters), with no clock needed.
REQ-030 Reset asserted mid-row or mid-frame SHALL discard partial data; the first en bit after release SHALL be bit 0 of row 0.

Structure
REQ-031 A shared package SHALL hold ROW_W, ROWS, the state encoding (IDLE=0, SHIFT=1, FULL=2), and the row order constants.
REQ-032 One sub-module, row_shifter, is natural: ROW_W shift register plus bit counter with a row_done output; the FSM and bank stay at top level.
REQ-033 The block SHALL replace the combinational row decode feeding the fma: bank slices map directly to in_*/u_* ports, and load drives the fma start.

Verification
REQ-034 Reset, then shift 12 rows where row r = {6'(r), 64'hA5A5_0000_0000_0000 + r}: expect row_valid pulses with row_idx 0..11, load=1 exactly one cycle after bit 840, and bank matching all rows.
REQ-035 Shift 35 bits, hold en=0 for 20 cycles, shift 35 more: expect row 0 to complete correctly with no extra row_valid.
REQ-036 In FULL, drive en=1 for 3 cycles with ack=0: expect ovf=1, bank unchanged, and load held; then ack=1: expect load=0 next cycle.
REQ-037 In FULL, drive ack=1 and en=1 with din=1 in the same cycle: expect load=0, state SHIFT, and the new frame's bit 0 equal to 1.
REQ-038 Assert abort mid-row 5: expect busy=0 and counters 0, bank rows 0-4 kept, and the next frame writing row 0 first.
REQ-039 Pulse rst asynchronously (between clock edges) mid-frame: expect all outputs 0 immediately and a clean 12-row frame accepted afterwards.
